div_reconstruct: RTL
====================

Name: div_reconstruct

Overview:
- Sequential signed multiply-add unit that rebuilds the dividend from a divider result: final_output = quotient * divisor + remainder.
- Sits on the result side of the divider/modulo top level. It accepts that block's quotient, remainder and original divisor.
- Used in-system for self-check and by benches as the inverse model of the divider.
- Radix-2 shift-add over magnitudes, then a sign fix-up and a remainder add.

Parameters:
DIVISOR_W, 16, divisor width (signed)
QUOT_W, 17, quotient and remainder width (signed)
OUT_W, QUOT_W+DIVISOR_W+1 (34), result width (signed); derived, never overridden

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
quotient  input  QUOT_W  signed quotient
divisor  input  DIVISOR_W  signed divisor
remainder  input  QUOT_W  signed remainder (sign follows dividend, truncating division)
valid_input  input  1  operands valid; sampled only in IDLE
busy  output  1  high while an operation is in flight (MULT/ADD/DONE)
valid_output  output  1  one-cycle pulse; final_output valid while high
final_output  output  OUT_W  signed reconstructed dividend

Behaviour:
- Reset (async, reset=1):
  - state=IDLE; busy=0, valid_output=0, final_output=0.
  - All internal registers cleared.
  - Any in-flight operation is aborted and never produces valid_output.
- States: IDLE, MULT, ADD, DONE.
- IDLE:
  - On a rising edge with valid_input=1, capture:
    - mcand = |quotient| (QUOT_W+1 bits unsigned)
    - mplier = |divisor| (DIVISOR_W+1 bits unsigned)
    - neg = sign(quotient) XOR sign(divisor)
    - remainder (sign-extended to OUT_W)
  - Clear the accumulator and the iteration counter; go to MULT.
  - Magnitudes are taken at the widened width, so -2^16 and -2^15 are exact.
- MULT:
  - One iteration per clock, DIVISOR_W+1 (17) iterations.
  - Each iteration: if mplier[0], acc += mcand << cnt; then mplier >>= 1 and cnt++.
  - After the last iteration go to ADD.
  - No early termination: latency is data-independent.
- ADD:
  - final_output <= (neg ? -acc : acc) + remainder_sext.
  - valid_output <= 1; go to DONE.
- DONE:
  - valid_output <= 0; go to IDLE.
  - final_output holds its value until the next ADD or reset.
- Latency:
  - Accept edge = edge 0; iterations on edges 1..17; ADD transition on edge 17.
  - final_output and valid_output registered on edge 18 (DIVISOR_W+2).
  - valid_output high for exactly one cycle.
  - Earliest next accept is edge 20; throughput is one operation per 20 cycles.
- busy:
  - Asserted from the cycle after the accept edge until DONE exits.
  - busy=0 only in IDLE.
- valid_input while busy: ignored, operands not resampled, no queuing.
- valid_input held high continuously: a new operation starts each time IDLE is reached.
- Arithmetic and width rules:
  - All arithmetic is two's complement at OUT_W. |q*d| <= 2^31 and |r| < 2^16, so no overflow is possible and no saturation exists.
  - quotient=0 or divisor=0: product is 0 and the output equals the sign-extended remainder. Latency is unchanged.

Test Plan:
- Negative quotient, positive divisor: reset 5 cycles, then quotient=-26, divisor=3, remainder=-2, valid_input pulse → valid_output high exactly at edge 18, final_output=-80, busy low from edge 19.
- Both at negative extremes: quotient=-65536, divisor=-32768, remainder=0 → final_output=+2147483648 (34'sh0_8000_0000).
- Positive extremes with negative remainder: quotient=65535, divisor=32767, remainder=-1 → final_output=2147385344.
- Zero product: quotient=0, divisor=-32768, remainder=5 → final_output=5 after the same 18-cycle latency.
- Input while busy: valid_input held high for 25 cycles with operands changed every cycle after accept → exactly one valid_output at edge 18, computed from the accept-edge operands; the second operation starts at edge 20.
- Reset mid-operation: assert reset at edge 8 of an operation → busy, valid_output and final_output go to 0 immediately with no later pulse. After release, quotient=7, divisor=-5, remainder=3 → final_output=-32.

Source files
------------

// File: rtl/div_reconstruct.sv
// Signed multiply-add that rebuilds a dividend from divider results:
// final_output = quotient * divisor + remainder, radix-2 shift-add over magnitudes.
module div_reconstruct #(
    parameter int DIVISOR_W = 16,
    parameter int QUOT_W    = 17,
    localparam int OUT_W    = QUOT_W + DIVISOR_W + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [QUOT_W-1:0]    quotient,
    input  logic [DIVISOR_W-1:0] divisor,
    input  logic [QUOT_W-1:0]    remainder,
    input  logic                 valid_input,
    output logic                 busy,
    output logic                 valid_output,
    output logic [OUT_W-1:0]     final_output
);

    localparam int MC_W  = QUOT_W + 1;
    localparam int MP_W  = DIVISOR_W + 1;
    localparam int CNT_W = $clog2(MP_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVISOR_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic               busy_next_s;
    logic [MC_W-1:0]    mcand_r;
    logic [MP_W-1:0]    mplier_r;
    logic               neg_r;
    logic [OUT_W-1:0]   rem_sext_r;
    logic [OUT_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [OUT_W-1:0]   mcand_ext_s;
    logic [OUT_W-1:0]   addend_s;
    logic [OUT_W-1:0]   signed_acc_s;
    logic [OUT_W-1:0]   result_s;

    // Magnitude at one bit wider than the operand, so the most negative value is exact.
    function automatic logic [MC_W-1:0] mag_quot(input logic [QUOT_W-1:0] v);
        logic [MC_W-1:0] ext;
        ext = {v[QUOT_W-1], v};
        if (ext[MC_W-1]) begin
            mag_quot = ~ext + {{(MC_W-1){1'b0}}, 1'b1};
        end else begin
            mag_quot = ext;
        end
    endfunction

    function automatic logic [MP_W-1:0] mag_div(input logic [DIVISOR_W-1:0] v);
        logic [MP_W-1:0] ext;
        ext = {v[DIVISOR_W-1], v};
        if (ext[MP_W-1]) begin
            mag_div = ~ext + {{(MP_W-1){1'b0}}, 1'b1};
        end else begin
            mag_div = ext;
        end
    endfunction

    // Next-state decode and the shift-add / sign fix-up datapath.
    always_comb begin
        state_next_s = state_r;
        mcand_ext_s  = {{(OUT_W-MC_W){1'b0}}, mcand_r};
        if (mplier_r[0]) begin
            addend_s = mcand_ext_s << cnt_r;
        end else begin
            addend_s = {OUT_W{1'b0}};
        end
        if (neg_r) begin
            signed_acc_s = {OUT_W{1'b0}} - acc_r;
        end else begin
            signed_acc_s = acc_r;
        end
        result_s = signed_acc_s + rem_sext_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_input) begin
                    state_next_s = ST_MULT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MULT: begin
                if (cnt_r == LAST_CNT) begin
                    state_next_s = ST_ADD;
                end else begin
                    state_next_s = ST_MULT;
                end
            end
            ST_ADD:  state_next_s = ST_DONE;
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
        busy_next_s = (state_next_s != ST_IDLE);
    end

    // State, operand capture, accumulation and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            busy         <= 1'b0;
            valid_output <= 1'b0;
            final_output <= {OUT_W{1'b0}};
            mcand_r      <= {MC_W{1'b0}};
            mplier_r     <= {MP_W{1'b0}};
            neg_r        <= 1'b0;
            rem_sext_r   <= {OUT_W{1'b0}};
            acc_r        <= {OUT_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            busy    <= busy_next_s;
            case (state_r)
                ST_IDLE: begin
                    valid_output <= 1'b0;
                    if (valid_input) begin
                        mcand_r    <= mag_quot(quotient);
                        mplier_r   <= mag_div(divisor);
                        neg_r      <= quotient[QUOT_W-1] ^ divisor[DIVISOR_W-1];
                        rem_sext_r <= {{(OUT_W-QUOT_W){remainder[QUOT_W-1]}}, remainder};
                        acc_r      <= {OUT_W{1'b0}};
                        cnt_r      <= {CNT_W{1'b0}};
                    end
                end
                ST_MULT: begin
                    // Fixed iteration count keeps latency independent of the data.
                    acc_r    <= acc_r + addend_s;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CNT_ONE;
                end
                ST_ADD: begin
                    final_output <= result_s;
                    valid_output <= 1'b1;
                end
                ST_DONE: begin
                    valid_output <= 1'b0;
                end
                default: begin
                    valid_output <= 1'b0;
                end
            endcase
        end
    end

endmodule
